// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl
//   Byte-addressed, big-endian data/instruction memory plus its access
//   controller, driven by the SPARC datapath through the MFA/MOC 4-phase
//   handshake. Serves byte/halfword/word loads (signed or unsigned) and stores
//   with a fixed latency, and flags misaligned accesses without touching memory.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset (memory array is kept)
//   mfa        in   1   memory function active; held high until moc is seen
//   rw         in   1   1 = load, 0 = store
//   op_type    in   2   00 byte, 01 halfword, 10/11 word
//   sign_ext   in   1   loads only: sign-extend byte/halfword when 1
//   addr       in   32  byte address; only addr[ADDR_W-1:0] is used
//   data_in    in   32  store data, right-justified
//   data_out   out  32  load result, right-justified and extended
//   moc        out  1   memory operation complete
//   busy       out  1   high while waiting or completing
//   align_err  out  1   misaligned access flag, valid while moc = 1
module sparc_mem_ctrl #(
  parameter int    ADDR_W    = 9,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "prog.mem"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mfa,
  input  logic        rw,
  input  logic [1:0]  op_type,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        busy,
  output logic        align_err
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  logic [7:0]        mem_q [DEPTH];
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        op_q;
  logic              sext_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_out_q;
  logic              moc_q;
  logic              busy_q;
  logic              align_q;

  logic [ADDR_W-1:0] a1_s, a2_s, a3_s;
  logic [31:0]       rd_word_s;
  logic              we_s;
  logic              unused_addr_hi_s;

  // Halfword needs addr[0]==0, word (including reserved 11) needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] a);
    case (op)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  // The big-endian fetch puts the addressed byte in bits [31:24]; shift it
  // down and extend according to the access size.
  function automatic logic [31:0] load_extend(input logic [1:0] op, input logic sx,
                                              input logic [31:0] w);
    case (op)
      2'b00:   return {{24{sx & w[31]}}, w[31:24]};
      2'b01:   return {{16{sx & w[31]}}, w[31:16]};
      default: return w;
    endcase
  endfunction

  assign unused_addr_hi_s = ^addr[31:ADDR_W];

  // Aligned accesses never cross the top of the array, so plain ADDR_W-bit
  // increments are enough.
  assign a1_s      = addr_q + ADDR_W'(1);
  assign a2_s      = addr_q + ADDR_W'(2);
  assign a3_s      = addr_q + ADDR_W'(3);
  assign rd_word_s = {mem_q[addr_q], mem_q[a1_s], mem_q[a2_s], mem_q[a3_s]};

  // A store commits only on the WAIT->DONE edge; reset during WAIT cancels it.
  assign we_s = (state_q == S_WAIT) && (cnt_q == 4'd0) && !rw_q && !reset;

  // Memory array write port; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      case (op_q)
        2'b00: begin
          mem_q[addr_q] <= wdata_q[7:0];
        end
        2'b01: begin
          mem_q[addr_q] <= wdata_q[15:8];
          mem_q[a1_s]   <= wdata_q[7:0];
        end
        default: begin
          mem_q[addr_q] <= wdata_q[31:24];
          mem_q[a1_s]   <= wdata_q[23:16];
          mem_q[a2_s]   <= wdata_q[15:8];
          mem_q[a3_s]   <= wdata_q[7:0];
        end
      endcase
    end
  end

  // Access controller FSM with registered handshake and data outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      op_q       <= 2'b00;
      sext_q     <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      data_out_q <= 32'h0000_0000;
      moc_q      <= 1'b0;
      busy_q     <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mfa) begin
            addr_q  <= addr[ADDR_W-1:0];
            rw_q    <= rw;
            op_q    <= op_type;
            sext_q  <= sign_ext;
            wdata_q <= data_in;
            busy_q  <= 1'b1;
            if (is_misaligned(op_type, addr[1:0])) begin
              state_q <= S_DONE;
              moc_q   <= 1'b1;
              align_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            moc_q   <= 1'b1;
            if (rw_q) begin
              data_out_q <= load_extend(op_q, sext_q, rd_word_s);
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (!mfa) begin
            state_q <= S_IDLE;
            moc_q   <= 1'b0;
            align_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          moc_q   <= 1'b0;
          align_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign moc       = moc_q;
  assign busy      = busy_q;
  assign align_err = align_q;

endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// Self-checking bench for sparc_mem_ctrl: a table of load/store vectors with
// expected results pushed to a scoreboard when driven and popped when moc
// rises, plus hand-written handshake, mfa-drop and reset-abort sequences.
module tb_sparc_mem_ctrl;

  localparam int LAT = 2;
  localparam int AW  = 9;

  logic        clk;
  logic        reset;
  logic        mfa;
  logic        rw;
  logic [1:0]  op_type;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        busy;
  logic        align_err;

  typedef struct {
    logic        rw;
    logic [1:0]  op;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        upd;
    logic        exp_al;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        align;
    int          lat;
  } exp_t;

  vec_t        tbl[21];
  exp_t        sb[$];
  logic [31:0] last_data;
  int          nvec;
  int          nfail;

  sparc_mem_ctrl #(
    .ADDR_W    (AW),
    .LATENCY   (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mfa       (mfa),
    .rw        (rw),
    .op_type   (op_type),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .moc       (moc),
    .busy      (busy),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request, wait for moc, compare against the scoreboard, hold mfa
  // for 'hold' extra cycles, then release and check the return to idle.
  task automatic do_access(input vec_t v, input int hold, input string tag);
    exp_t e;
    int   edges;
    bit   got;
    @(negedge clk);
    mfa      = 1'b1;
    rw       = v.rw;
    op_type  = v.op;
    sign_ext = v.sx;
    addr     = v.addr;
    data_in  = v.wd;
    e.data   = v.upd ? v.exp_d : last_data;
    if (v.upd) last_data = v.exp_d;
    e.align  = v.exp_al;
    e.lat    = v.exp_al ? 1 : LAT;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Request is latched; scrambling the inputs must not affect the access.
    rw       = ~v.rw;
    op_type  = ~v.op;
    sign_ext = ~v.sx;
    addr     = ~v.addr;
    data_in  = ~v.wd;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (moc) got = 1'b1;
    end
    if (!got) begin
      nvec++;
      nfail++;
      $display("FAIL %s timeout: moc low after %0d edges, expected high", tag, edges);
    end
    e = sb.pop_front();
    check({tag, " latency"}, 32'(edges), 32'(e.lat));
    check({tag, " data_out"}, data_out, e.data);
    check({tag, " align_err"}, {31'b0, align_err}, {31'b0, e.align});
    check({tag, " busy"}, {31'b0, busy}, 32'h1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " moc held"}, {31'b0, moc}, 32'h1);
    end
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " moc release"}, {31'b0, moc}, 32'h0);
    check({tag, " busy release"}, {31'b0, busy}, 32'h0);
    check({tag, " align release"}, {31'b0, align_err}, 32'h0);
  endtask

  initial begin
    exp_t e;
    nvec      = 0;
    nfail     = 0;
    last_data = 32'h0000_0000;
    reset     = 1'b1;
    mfa       = 1'b0;
    rw        = 1'b0;
    op_type   = 2'b00;
    sign_ext  = 1'b0;
    addr      = 32'h0000_0000;
    data_in   = 32'h0000_0000;

    // Program image: byte i holds i, except bytes 0..3 = DE AD BE EF.
    for (int i = 0; i < (1 << AW); i++) dut.mem_q[i] <= 8'(i);
    dut.mem_q[0] <= 8'hDE;
    dut.mem_q[1] <= 8'hAD;
    dut.mem_q[2] <= 8'hBE;
    dut.mem_q[3] <= 8'hEF;

    //         rw    op     sx    addr          wd            exp_d         upd   al
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h12345678, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'h0,        32'h00000034, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0,        32'h00005678, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h123456F0, 32'h0,        1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'b00, 1'b1, 32'h0000_0003, 32'h0,        32'hFFFFFFF0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0,        32'h000000F0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h00009999, 32'h0,        1'b0, 1'b1};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0,        32'h00000005, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_0204, 32'h0,        32'h00000004, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'b01, 1'b1, 32'h0000_01FE, 32'h0,        32'hFFFFFEFF, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_01FC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 1'b0, 32'h0000_01FC, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'h0,        32'h12345678, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'hABCD8001, 32'h0,        1'b0, 1'b0};
    tbl[16] = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h80012223, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[18] = '{1'b1, 2'b01, 1'b1, 32'h0000_0020, 32'h0,        32'hFFFF8001, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 2'b01, 1'b1, 32'h0000_000A, 32'h0,        32'h00005678, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'hDEADBEF0, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset moc", {31'b0, moc}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset align_err", {31'b0, align_err}, 32'h0);
    check("reset data_out", data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 21; k++) begin
      do_access(tbl[k], 0, $sformatf("vec%0d", k));
    end

    // Handshake: mfa held 5 cycles after moc keeps moc high.
    do_access('{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'h12345678, 1'b1, 1'b0}, 5, "hold");

    // mfa dropped while in WAIT: access completes, DONE exits on the next edge.
    @(negedge clk);
    mfa = 1'b1; rw = 1'b1; op_type = 2'b00; sign_ext = 1'b1; addr = 32'h0000_0001;
    e.data = 32'hFFFFFFAD; e.align = 1'b0; e.lat = LAT;
    sb.push_back(e);
    last_data = 32'hFFFFFFAD;
    @(posedge clk);
    #1;
    mfa = 1'b0;
    @(posedge clk);
    #1;
    check("drop moc in wait", {31'b0, moc}, 32'h0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("drop moc done", {31'b0, moc}, 32'h1);
    check("drop data_out", data_out, e.data);
    @(posedge clk);
    #1;
    check("drop moc exit", {31'b0, moc}, 32'h0);
    check("drop busy exit", {31'b0, busy}, 32'h0);

    // Reset during WAIT aborts a word store before it commits.
    @(negedge clk);
    mfa = 1'b1; rw = 1'b0; op_type = 2'b10; addr = 32'h0000_0010; data_in = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    check("abort busy in wait", {31'b0, busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    mfa   = 1'b0;
    #1;
    check("abort moc", {31'b0, moc}, 32'h0);
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort data_out", data_out, 32'h0);
    last_data = 32'h0000_0000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_access('{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h10111213, 1'b1, 1'b0}, 0, "abort reload");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
